// File: rtl/piso_serializer.sv
// Parallel-in, serial-out stage with a one-word holding buffer for gapless streaming.
// Define PISO_PARITY_BIT_EN to append an even-parity bit to every frame.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             w,
    output logic             w_valid,
    output logic             w_last,
    output logic             busy
);

`ifdef PISO_PARITY_BIT_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(FRAME - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_hold;
    logic             r_holdFull;
    logic [FRAME-1:0] r_shift;
    logic [CW-1:0]    r_count;

    logic             w_lastBit;
    logic             w_loadNow;
    logic             w_accept;
    logic [FRAME-1:0] w_loadWord;

    assign w_lastBit = (r_state == SHIFT) && (r_count == LAST_COUNT);
    assign w_loadNow = r_holdFull && ((r_state == IDLE) || w_lastBit);
    assign w_accept  = din_valid && din_ready;

    // The parity bit sits at the tail end of the shift order, so it always leaves last.
`ifdef PISO_PARITY_BIT_EN
    logic w_parity;
    assign w_parity   = ^r_hold;
    assign w_loadWord = MSB_FIRST ? {r_hold, w_parity} : {w_parity, r_hold};
`else
    assign w_loadWord = r_hold;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_hold     <= '0;
            r_holdFull <= 1'b0;
            r_shift    <= '0;
            r_count    <= '0;
        end else begin
            if (w_accept) begin
                r_hold     <= din;
                r_holdFull <= 1'b1;
            end else if (w_loadNow) begin
                r_holdFull <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_loadNow) begin
                        r_shift <= w_loadWord;
                        r_count <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_lastBit) begin
                        r_count <= '0;
                        if (w_loadNow) begin
                            r_shift <= w_loadWord;
                        end else begin
                            r_shift <= '0;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_count <= r_count + CW'(1);
                        if (MSB_FIRST) begin
                            r_shift <= {r_shift[FRAME-2:0], 1'b0};
                        end else begin
                            r_shift <= {1'b0, r_shift[FRAME-1:1]};
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Ready never looks at din_valid, which keeps the handshake free of combinational loops.
    assign din_ready = !r_holdFull || w_loadNow;
    assign w_valid   = (r_state == SHIFT);
    assign w         = w_valid && (MSB_FIRST ? r_shift[FRAME-1] : r_shift[0]);
    assign w_last    = w_lastBit;
    assign busy      = (r_state == SHIFT) || r_holdFull;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed, table-driven bench for piso_serializer: one MSB-first and one LSB-first instance.
// Expected frames include the parity bit when PISO_PARITY_BIT_EN is defined.
module tb_piso_serializer;

`ifdef PISO_PARITY_BIT_EN
    localparam int FR     = 9;
    localparam bit PAR_EN = 1'b1;
`else
    localparam int FR     = 8;
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] dinM = '0, dinL = '0;
    logic validM = 1'b0, validL = 1'b0;
    logic readyM, wM, vM, lastM, busyM;
    logic readyL, wL, vL, lastL, busyL;
    logic selLsb = 1'b0;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .din(dinM), .din_valid(validM), .din_ready(readyM),
        .w(wM), .w_valid(vM), .w_last(lastM), .busy(busyM)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dutLsb (
        .clk(clk), .rst(rst), .din(dinL), .din_valid(validL), .din_ready(readyL),
        .w(wL), .w_valid(vL), .w_last(lastL), .busy(busyL)
    );

    wire obsReady = selLsb ? readyL : readyM;
    wire obsW     = selLsb ? wL     : wM;
    wire obsValid = selLsb ? vL     : vM;
    wire obsLast  = selLsb ? lastL  : lastM;
    wire obsBusy  = selLsb ? busyL  : busyM;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] data;
        logic       lsb;
        logic [7:0] order;
        logic       par;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [63:0] appendFrame(input logic [63:0] s, input logic [7:0] order, input logic par);
        logic [63:0] r;
        r = {s[55:0], order};
        if (PAR_EN) r = {r[62:0], par};
        return r;
    endfunction

    // Sends one word on the selected instance and checks latency and every bit of the frame.
    task automatic applyStimulus(input vec_t v, input int idx);
        logic expBit;
        selLsb = v.lsb;
        @(negedge clk);
        if (v.lsb) begin dinL = v.data; validL = 1'b1; end
        else       begin dinM = v.data; validM = 1'b1; end
        #1 checkOutput($sformatf("v%0d ready", idx), 64'(obsReady), 64'd1);
        @(posedge clk);
        @(negedge clk);
        validL = 1'b0;
        validM = 1'b0;
        dinL = 8'h55;
        dinM = 8'h55;
        #1 checkOutput($sformatf("v%0d latency valid", idx), 64'(obsValid), 64'd0);
        checkOutput($sformatf("v%0d busy holding", idx), 64'(obsBusy), 64'd1);
        @(negedge clk);
        for (int i = 0; i < FR; i++) begin
            expBit = (i < 8) ? v.order[7-i] : v.par;
            #1;
            checkOutput($sformatf("v%0d bit%0d w", idx, i), 64'(obsW), 64'(expBit));
            checkOutput($sformatf("v%0d bit%0d valid", idx, i), 64'(obsValid), 64'd1);
            checkOutput($sformatf("v%0d bit%0d last", idx, i), 64'(obsLast), 64'(i == FR - 1));
            @(negedge clk);
        end
        #1 checkOutput($sformatf("v%0d valid after", idx), 64'(obsValid), 64'd0);
        checkOutput($sformatf("v%0d busy after", idx), 64'(obsBusy), 64'd0);
        checkOutput($sformatf("v%0d last after", idx), 64'(obsLast), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [63:0] stream, expStream;
        int          validCount, transfers, idx;
        logic [7:0]  words[3];
        logic        xfer;

        vecs[0] = '{8'hA5, 1'b0, 8'hA5, 1'b0};
        vecs[1] = '{8'h01, 1'b0, 8'h01, 1'b1};
        vecs[2] = '{8'h07, 1'b0, 8'h07, 1'b1};
        vecs[3] = '{8'h3C, 1'b0, 8'h3C, 1'b0};
        vecs[4] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
        vecs[5] = '{8'h01, 1'b1, 8'h80, 1'b1};
        vecs[6] = '{8'h07, 1'b1, 8'hE0, 1'b1};
        vecs[7] = '{8'h3C, 1'b1, 8'h3C, 1'b0};

        // Reset state
        #3 checkOutput("in-reset valid", 64'(vM), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset w", 64'({wM, wL}), 64'd0);
        checkOutput("reset valid", 64'({vM, vL}), 64'd0);
        checkOutput("reset last", 64'({lastM, lastL}), 64'd0);
        checkOutput("reset busy", 64'({busyM, busyL}), 64'd0);
        checkOutput("reset ready", 64'({readyM, readyL}), 64'd3);

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

        // Back-to-back streaming of three words
        selLsb = 1'b0;
        words[0] = 8'hF0; words[1] = 8'h0F; words[2] = 8'h3C;
        stream = '0; validCount = 0; transfers = 0; idx = 0;
        @(negedge clk);
        for (int c = 0; c <= 3 * FR + 4; c++) begin
            validM = (idx < 3);
            dinM   = (idx < 3) ? words[idx] : 8'h00;
            #1;
            checkOutput($sformatf("stream c%0d valid", c), 64'(vM), 64'((c >= 2) && (c <= 3 * FR + 1)));
            if (c <= 2 * FR + 1)
                checkOutput($sformatf("stream c%0d ready", c), 64'(readyM),
                            64'((c <= 1) || (c == FR + 1) || (c == 2 * FR + 1)));
            if (vM) begin
                stream = {stream[62:0], wM};
                validCount++;
            end
            xfer = validM && readyM;
            @(posedge clk);
            if (xfer) begin
                idx++;
                transfers++;
            end
            @(negedge clk);
        end
        validM = 1'b0;
        expStream = appendFrame(appendFrame(appendFrame(64'd0, 8'hF0, 1'b0), 8'h0F, 1'b0), 8'h3C, 1'b0);
        checkOutput("stream transfers", 64'(transfers), 64'd3);
        checkOutput("stream valid count", 64'(validCount), 64'(3 * FR));
        checkOutput("stream bits", stream, expStream);

        // Backpressure: a third word offered while hold is full must be ignored
        stream = '0; validCount = 0; transfers = 0;
        for (int c = 0; c <= 2 * FR + 4; c++) begin
            validM = (c <= 5);
            dinM   = (c == 0) ? 8'hA5 : (c == 1) ? 8'h3C : 8'hFF;
            #1;
            if ((c >= 2) && (c <= 5))
                checkOutput($sformatf("bp c%0d ready", c), 64'(readyM), 64'd0);
            if (vM) begin
                stream = {stream[62:0], wM};
                validCount++;
            end
            xfer = validM && readyM;
            @(posedge clk);
            if (xfer) transfers++;
            @(negedge clk);
        end
        validM = 1'b0;
        expStream = appendFrame(appendFrame(64'd0, 8'hA5, 1'b0), 8'h3C, 1'b0);
        checkOutput("bp transfers", 64'(transfers), 64'd2);
        checkOutput("bp valid count", 64'(validCount), 64'(2 * FR));
        checkOutput("bp bits", stream, expStream);
        checkOutput("bp idle busy", 64'(busyM), 64'd0);

        // Asynchronous reset in the middle of a frame
        dinM = 8'hFF; validM = 1'b1;
        @(posedge clk);
        @(negedge clk);
        validM = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        checkOutput("midword valid before rst", 64'(vM), 64'd1);
        checkOutput("midword w before rst", 64'(wM), 64'd1);
        #1 rst = 1'b1;
        #1;
        checkOutput("async rst valid", 64'(vM), 64'd0);
        checkOutput("async rst busy", 64'(busyM), 64'd0);
        checkOutput("async rst w", 64'(wM), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus('{8'h81, 1'b0, 8'h81, 1'b0}, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out stage directly upstream of the serial sequence/parity detector.
- Accepts WIDTH-bit words over a valid/ready handshake. Emits them one bit per clock on `w`, with a qualifying valid strobe.
- A one-word holding buffer lets consecutive words stream with no idle cycle between them.

Parameters:
- WIDTH, 8, data word width in bits (legal range 2..32).
- MSB_FIRST, 1, 1 = bit WIDTH-1 is shifted out first; 0 = bit 0 is shifted out first.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- din  input  WIDTH  parallel data word.
- din_valid  input  1  din holds a word to transfer.
- din_ready  output  1  block can accept a word this cycle.
- w  output  1  serial bit out; feeds the detector's w input.
- w_valid  output  1  w carries a real data bit this cycle.
- w_last  output  1  current w is the final bit of the frame.
- busy  output  1  shifter active or holding buffer occupied.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst is asynchronous and active-high: it clears state immediately, with no clock edge needed.
- Reset values:
  - state = IDLE; hold_full = 0; bit counter = 0; shift register = 0.
  - Outputs: w = 0, w_valid = 0, w_last = 0, busy = 0.
  - din_ready = 1 as soon as reset is released.
- Handshake:
  - A word is transferred on a rising edge where din_valid && din_ready.
  - din may change freely when no transfer occurs.
- Holding register:
  - An accepted word is written into the holding register; hold_full = 1 after that edge.
  - load_now = hold_full && (state == IDLE || last-bit cycle).
  - din_ready = !hold_full || load_now. This is a combinational path from state only; it never depends on din_valid.
  - Simultaneous load_now and a new accept: the shifter takes the old hold word, the hold register takes the new word, and hold_full stays 1.
- State machine:
  - IDLE:
    - w_valid = 0, w = 0.
    - If load_now: copy hold into the shift register, clear counter, go to SHIFT.
  - SHIFT:
    - w_valid = 1; w = shift register MSB (MSB_FIRST = 1) or LSB (MSB_FIRST = 0).
    - Each cycle, shift by one and increment the counter.
    - Last-bit cycle is counter == FRAME-1, where FRAME = WIDTH (or WIDTH+1 with the optional feature); w_last = 1 in this cycle only.
    - On the last-bit cycle: if load_now, reload from hold and stay in SHIFT (zero-gap streaming). Otherwise go to IDLE.
- Latency:
  - Accept at edge N -> hold_full after N -> shifter loaded at N+1.
  - The first bit appears on w with w_valid = 1 in the cycle after edge N+1, i.e. 2 clocks after the accept.
- Throughput and bit timing:
  - Sustained throughput is one word per FRAME cycles.
  - Each bit is held for exactly one clock.
- Outputs:
  - All outputs are registered or decoded from registered state only; nothing combinational from din.
  - busy = (state == SHIFT) || hold_full.
- Counter width: clog2(WIDTH+1) bits. The counter never wraps past FRAME-1; it is cleared on every load.
- Reset mid-word:
  - The current frame and the hold contents are discarded; w_valid drops immediately.
  - After release, the next accepted word starts a fresh frame.
- Shift fill: vacated bit positions in the shift register are filled with 0.

Optional Feature:
- Macro: PISO_PARITY_BIT_EN.
- Defined:
  - Each frame is WIDTH+1 bits: the data bits followed by one even-parity bit, equal to the XOR of all data bits.
  - The parity bit is computed at load time and stored alongside the word.
  - w_last and w_valid are asserted on the parity bit.
  - The counter end value becomes WIDTH.
- Undefined: frame = WIDTH data bits only, and no parity logic is synthesized.

Test Plan:
- Single word, MSB first: WIDTH = 8, din = 8'hA5 accepted at edge 0.
  - w_valid high for cycles 2..9.
  - w = 1,0,1,0,0,1,0,1.
  - w_last only in cycle 9; state returns to IDLE, busy = 0 by cycle 10.
- LSB first: MSB_FIRST = 0, din = 8'hA5 -> w = 1,0,1,0,0,1,0,1 reversed bit order, i.e. bit 0 first: 1,0,1,0,0,1,0,1 applied to 8'b10100101 gives 1,0,1,0,0,1,0,1. Add a second case with din = 8'h01: w = 1,0,0,0,0,0,0,0.
- Back-to-back streaming: din_valid held high with words 8'hF0, 8'h0F, 8'h3C.
  - 24 contiguous w_valid cycles with no gap.
  - din_ready drops while hold is full and pulses high in each last-bit cycle.
  - Exactly 3 transfers occur.
- Backpressure: din_valid high with hold_full = 1 and the shifter mid-word -> din_ready = 0, and din changes are not captured.
- Reset mid-word: assert rst asynchronously during bit 4 of 8'hFF.
  - w_valid = 0 and busy = 0 immediately.
  - After release, 8'h81 serializes cleanly as 1,0,0,0,0,0,0,1.
- PISO_PARITY_BIT_EN defined:
  - 8'hA5 -> 9 bits, with final bit 0.
  - 8'h07 -> 9 bits, with final bit 1.
  - w_last is asserted on bit 9 in both cases.
